// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encodings, I/O address and byte-lane helpers for mem_responder
package mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

  // The single memory-mapped I/O word: switches on read, hex display on write
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  localparam logic [15:0] LANE_HI = 16'hFF00;
  localparam logic [15:0] LANE_LO = 16'h00FF;

  // Byte-lane enables are active-low; a selected lane contributes all ones
  function automatic logic [15:0] lane_mask(input logic ub_n, input logic lb_n);
    return (ub_n ? 16'h0000 : LANE_HI) | (lb_n ? 16'h0000 : LANE_LO);
  endfunction

endpackage

// File: rtl/tri_buffer_16.sv
// rtl/tri_buffer_16.sv - 16-bit tristate driver onto a shared bus
module tri_buffer_16 (
  input  logic        en,
  input  logic [15:0] d,
  output wire  [15:0] q
);

  assign q = en ? d : 16'hzzzz;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated SRAM-style responder with byte lanes and one I/O word
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  inout  wire  [15:0] Mem_Bus,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [15:0] S,
  output logic        R,
  output logic [15:0] Hex_out
);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] cap_addr;
  logic [15:0] cap_data;
  logic        cap_ub;
  logic        cap_lb;
  logic        cap_write;
  logic [15:0] rd_data;

  logic [15:0] ram [0:(1<<ADDR_W)-1];

  logic        start;
  logic        enter_done;
  logic        commit;
  logic        drive_en;
  logic [15:0] src_addr;
  logic        src_ub;
  logic        src_lb;
  logic [15:0] rd_next;
  logic [15:0] wr_mask;
  logic [15:0] hex_next;

  // Decode access start and the transition into DONE (direct from IDLE when there are no wait states)
  always_comb begin
    start      = (state == ST_IDLE) && !CE && (!OE || !WE);
    enter_done = 1'b0;
    if (start && (WAIT_STATES == 0)) enter_done = 1'b1;
    if ((state == ST_BUSY) && !CE && (cnt == 4'd1)) enter_done = 1'b1;
  end

  // Read data source: live inputs when DONE is entered straight from IDLE, captured values otherwise
  always_comb begin
    src_addr = cap_addr;
    src_ub   = cap_ub;
    src_lb   = cap_lb;
    if (state == ST_IDLE) begin
      src_addr = ADDR;
      src_ub   = UB;
      src_lb   = LB;
    end
    rd_next = ((src_addr == IO_ADDR) ? S : ram[src_addr[ADDR_W-1:0]]) & lane_mask(src_ub, src_lb);
  end

  // Write-side merge, commit strobe, bus drive enable and ready
  always_comb begin
    wr_mask  = lane_mask(cap_ub, cap_lb);
    hex_next = (Hex_out & ~wr_mask) | (cap_data & wr_mask);
    commit   = (state == ST_DONE) && cap_write;
    drive_en = ((state == ST_DONE) || (state == ST_HOLD)) && !cap_write && !CE && !OE;
    R        = (state == ST_DONE);
  end

  // Access sequencer: capture, wait-state count, completion, release handshake
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 16'h0000;
      cap_data  <= 16'h0000;
      cap_ub    <= 1'b0;
      cap_lb    <= 1'b0;
      cap_write <= 1'b0;
      rd_data   <= 16'h0000;
      Hex_out   <= 16'h0000;
    end else begin
      if (enter_done) rd_data <= rd_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cap_addr  <= ADDR;
            cap_data  <= Mem_Bus;
            cap_ub    <= UB;
            cap_lb    <= LB;
            cap_write <= !WE;
            cnt       <= 4'(WAIT_STATES);
            state     <= (WAIT_STATES == 0) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (CE) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (commit && (cap_addr == IO_ADDR)) Hex_out <= hex_next;
          state <= ST_HOLD;
        end
        default: begin
          if (CE || (OE && WE)) state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM commit on the edge that ends DONE; contents survive reset
  always_ff @(posedge Clk) begin
    if (!Reset && commit && (cap_addr != IO_ADDR)) begin
      if (!cap_ub) ram[cap_addr[ADDR_W-1:0]][15:8] <= cap_data[15:8];
      if (!cap_lb) ram[cap_addr[ADDR_W-1:0]][7:0]  <= cap_data[7:0];
    end
  end

  tri_buffer_16 u_tri (
    .en (drive_en),
    .d  (rd_data),
    .q  (Mem_Bus)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  localparam int WS = 2;

  logic        Clk;
  logic        Reset;
  logic [15:0] ADDR;
  wire  [15:0] Mem_Bus;
  logic        CE, OE, WE, UB, LB;
  logic [15:0] S;
  logic        R;
  logic [15:0] Hex_out;

  logic [15:0] bus_drv;
  logic        bus_en;
  assign Mem_Bus = bus_en ? bus_drv : 16'hzzzz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q [$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        ub;
    logic        lb;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t tbl [18];

  mem_responder #(.WAIT_STATES(WS), .ADDR_W(8)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .ADDR    (ADDR),
    .Mem_Bus (Mem_Bus),
    .CE      (CE),
    .OE      (OE),
    .WE      (WE),
    .UB      (UB),
    .LB      (LB),
    .S       (S),
    .R       (R),
    .Hex_out (Hex_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                              input logic ub, input logic lb, input logic [15:0] exp_rd);
    ADDR = addr;
    UB   = ub;
    LB   = lb;
    CE   = 1'b0;
    if (wr) begin
      WE      = 1'b0;
      OE      = 1'b1;
      bus_drv = data;
      bus_en  = 1'b1;
    end else begin
      WE     = 1'b1;
      OE     = 1'b0;
      bus_en = 1'b0;
      exp_q.push_back(exp_rd);
    end
  endtask

  task automatic wait_done(input logic is_read, input string tag);
    int lat;
    logic [15:0] e;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (R === 1'b1) begin
        lat = n;
        break;
      end
    end
    check16({tag, " latency"}, 16'(lat), 16'(WS + 1));
    e = 16'h0000;
    if (is_read) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      end else begin
        e = exp_q.pop_front();
      end
    end
    if (lat != 0) begin
      if (is_read) check16({tag, " data done"}, Mem_Bus, e);
      @(negedge Clk);
      check16({tag, " r single"}, 16'(R), 16'd0);
      if (is_read) check16({tag, " data hold"}, Mem_Bus, e);
    end
  endtask

  task automatic release_bus(input string tag);
    CE     = 1'b1;
    OE     = 1'b1;
    WE     = 1'b1;
    bus_en = 1'b0;
    @(negedge Clk);
    check16({tag, " released drive"}, 16'(dut.drive_en), 16'd0);
  endtask

  initial begin
    int pulses;
    tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
    tbl[2]  = '{1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 16'h0020, 16'hAB00, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'hAB34, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0034, 16'h0000};
    tbl[6]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'hAB00, 16'h0000};
    tbl[7]  = '{1'b1, 16'h0120, 16'h5555, 1'b1, 1'b1, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'hAB34, 16'h0000};
    tbl[9]  = '{1'b1, 16'h0105, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h7777, 16'h0000};
    tbl[11] = '{1'b1, 16'h00FF, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[12] = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 16'h0000};
    tbl[13] = '{1'b1, 16'hFFFF, 16'h00C3, 1'b0, 1'b0, 16'h0000, 16'h00C3};
    tbl[14] = '{1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h00C3};
    tbl[15] = '{1'b1, 16'hFFFF, 16'h99AA, 1'b1, 1'b0, 16'h0000, 16'h00AA};
    tbl[16] = '{1'b1, 16'hFFFF, 16'h7700, 1'b0, 1'b1, 16'h0000, 16'h77AA};
    tbl[17] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h005A, 16'h77AA};

    Reset = 1'b1; ADDR = 16'h0000; CE = 1'b1; OE = 1'b1; WE = 1'b1;
    UB = 1'b0; LB = 1'b0; S = 16'h5A5A; bus_drv = 16'h0000; bus_en = 1'b0;
    repeat (3) @(negedge Clk);
    check16("reset r", 16'(R), 16'd0);
    check16("reset hex", Hex_out, 16'h0000);
    check16("reset drive", 16'(dut.drive_en), 16'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 18; i++) begin
      start_access(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].ub, tbl[i].lb, tbl[i].exp_rd);
      wait_done(!tbl[i].wr, $sformatf("vec%0d", i));
      check16($sformatf("vec%0d hex", i), Hex_out, tbl[i].exp_hex);
      release_bus($sformatf("vec%0d", i));
    end

    // Abort: CE rises in the first BUSY cycle of a write
    start_access(1'b1, 16'h0005, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
    @(negedge Clk);
    CE = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge Clk);
      if (R === 1'b1) pulses++;
    end
    check16("abort r pulses", 16'(pulses), 16'd0);
    WE = 1'b1; bus_en = 1'b0;
    @(negedge Clk);
    start_access(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h7777);
    wait_done(1'b1, "abort readback");
    release_bus("abort readback");

    // Hold: CE/OE kept low after DONE, then a one-cycle OE release
    start_access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF);
    wait_done(1'b1, "hold first");
    pulses = 0;
    repeat (5) begin
      @(negedge Clk);
      if (R === 1'b1) pulses++;
    end
    check16("hold r pulses", 16'(pulses), 16'd0);
    check16("hold bus", Mem_Bus, 16'hBEEF);
    OE = 1'b1;
    @(negedge Clk);
    check16("hold oe release drive", 16'(dut.drive_en), 16'd0);
    start_access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF);
    wait_done(1'b1, "hold second");
    release_bus("hold second");

    // Reset during BUSY of a write
    start_access(1'b1, 16'hFFFF, 16'h00C3, 1'b0, 1'b0, 16'h0000);
    wait_done(1'b0, "pre reset hex");
    check16("pre reset hex value", Hex_out, 16'h00C3);
    release_bus("pre reset hex");
    start_access(1'b1, 16'h0010, 16'h4242, 1'b0, 1'b0, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check16("midreset r", 16'(R), 16'd0);
    check16("midreset drive", 16'(dut.drive_en), 16'd0);
    check16("midreset hex", Hex_out, 16'h0000);
    CE = 1'b1; WE = 1'b1; bus_en = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    start_access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF);
    wait_done(1'b1, "midreset readback");
    release_bus("midreset readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WAIT_STATES, 2, number of BUSY cycles between access capture and DONE (legal range 0..15).
REQ-002 Parameter: ADDR_W, 8, word-address width of internal RAM (depth 2^ADDR_W x 16).
REQ-003 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: ADDR  input  16  word address from CPU MAR.
REQ-006 Port: Mem_Bus  inout  16  bidirectional data; driven by block only as in REQ-015, else high-Z.
REQ-007 Port: CE  input  1  chip enable, active-low.
REQ-008 Port: OE  input  1  output (read) enable, active-low.
REQ-009 Port: WE  input  1  write enable, active-low.
REQ-010 Port: UB  input  1  upper byte lane [15:8] enable, active-low.
REQ-011 Port: LB  input  1  lower byte lane [7:0] enable, active-low.
REQ-012 Port: S  input  16  switch value returned on I/O read.
REQ-013 Port: R  output  1  ready; high exactly one cycle when an access completes.
REQ-014 Port: Hex_out  output  16  latched I/O write value for hex display.

Function
REQ-015 Mem_Bus shall be driven only when state is DONE or HOLD, captured access is a read, and CE=0 and OE=0 in that cycle.
REQ-016 States: IDLE, BUSY, DONE, HOLD.
REQ-017 IDLE: when CE=0 and (OE=0 or WE=0), capture ADDR, Mem_Bus, UB, LB and kind (write if WE=0, else read; WE wins if both low); go BUSY with counter=WAIT_STATES, or straight to DONE if WAIT_STATES=0.
REQ-018 BUSY: decrement counter each cycle; when counter reaches 1, next state DONE (exactly WAIT_STATES BUSY cycles).
REQ-019 BUSY abort: if CE=1 in any BUSY cycle, return to IDLE; no write, R never asserted.
REQ-020 DONE: R=1 for this single cycle; a captured write commits to RAM or Hex_out at the clock edge ending DONE; next state HOLD.
REQ-021 HOLD: R=0; stay until CE=1 or (OE=1 and WE=1), then IDLE; no new access may start without this release.
REQ-022 Total latency: capture edge to R high = WAIT_STATES+1 cycles.
REQ-023 Address 16'hFFFF is I/O: read returns S; write loads Hex_out with lane-masked data (unselected lanes keep old value); RAM untouched.
REQ-024 Any other address uses ADDR[ADDR_W-1:0] (upper bits ignored, aliasing wraps).
REQ-025 Write lanes: UB=0 writes [15:8], LB=0 writes [7:0]; both high is a completed no-op write (R still pulses).
REQ-026 Read lanes: selected lanes return stored data, unselected lanes read 0; read data is registered at DONE entry and held stable through HOLD.
REQ-027 Reset mid-access: state to IDLE, pending write discarded, R=0, Mem_Bus high-Z next cycle.

Reset
REQ-028 On Reset=1 at a rising edge: state=IDLE, counter=0, R=0, Hex_out=16'h0000, Mem_Bus high-Z, captured registers=0.
REQ-029 RAM contents shall not be cleared by reset.

Structure
REQ-030 Shared package mem_pkg shall hold the state enum, IO_ADDR=16'hFFFF and lane-mask helper constants.
REQ-031 Tristate output shall use the existing tri_buffer_16 sub-module; RAM is an inferred array in this module.

Verification
REQ-032 WAIT_STATES=2; write 16'hBEEF to 0x0010 (UB=LB=0), release, read 0x0010 -> R high 3 cycles after capture each time, read returns 16'hBEEF.
REQ-033 Write 16'h1234 to 0x0020 then write 16'hAB00 with LB=1, UB=0 -> read returns 16'hAB34; read with UB=1 returns 16'h0034.
REQ-034 S=16'h5A5A, read 0xFFFF -> Mem_Bus=16'h5A5A in DONE; write 16'h00C3 to 0xFFFF -> Hex_out=16'h00C3, RAM[0xFF] unchanged.
REQ-035 Start write to 0x0005, raise CE on first BUSY cycle -> R stays 0, subsequent read of 0x0005 returns prior value.
REQ-036 Hold CE=OE=0 after DONE -> stays HOLD, no second R pulse; raise OE one cycle -> IDLE, next access proceeds.
REQ-037 Assert Reset during BUSY of a write with Hex_out=16'h00C3 -> R=0, Mem_Bus high-Z, Hex_out=0, write not committed.
